// File: rtl/uart_pkg.sv
// ---------------------------------------------------------------------------
// uart_pkg
// Shared definitions for the memory-mapped UART transmitter:
//   - register offsets decoded from the word address addr[1:0]
//   - STATUS register bit positions
//   - transmitter FSM state encoding
// ---------------------------------------------------------------------------
package uart_pkg;

    localparam logic [1:0] UART_TXDATA = 2'd0;
    localparam logic [1:0] UART_STATUS = 2'd1;
    localparam logic [1:0] UART_DIV    = 2'd2;
    localparam logic [1:0] UART_CTRL   = 2'd3;

    localparam int STAT_FULL      = 0;
    localparam int STAT_EMPTY     = 1;
    localparam int STAT_BUSY      = 2;
    localparam int STAT_OVF       = 3;
    localparam int STAT_COUNT_LSB = 8;
    localparam int STAT_COUNT_W   = 4;

    localparam int CTRL_EN        = 0;

    typedef enum logic [1:0] {
        TX_IDLE,
        TX_START,
        TX_DATA,
        TX_STOP
    } uart_tx_state_t;

endpackage

// File: rtl/sync_fifo.sv
// ---------------------------------------------------------------------------
// sync_fifo
// Single-clock FIFO with a combinational head (first-word fall-through).
// A push into a full FIFO is accepted only when a pop happens in the same
// cycle; a pop of an empty FIFO is ignored.
// Ports:
//   clk, reset_n      clock, asynchronous active-low reset (pointers/count)
//   push, wr_data     write request and data
//   pop               remove head entry
//   rd_data           current head entry (valid while !empty)
//   full, empty       occupancy flags
//   count             number of stored entries, 0..DEPTH
// ---------------------------------------------------------------------------
module sync_fifo #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 8
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     push,
    input  logic [DATA_W-1:0]        wr_data,
    input  logic                     pop,
    output logic [DATA_W-1:0]        rd_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]     rd_ptr;
    logic [AW-1:0]     wr_ptr;
    logic              do_pop;
    logic              do_push;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_pop  = pop && !empty;
    // When full, the slot being written is the one the pop frees this edge.
    assign do_push = push && (!full || do_pop);
    assign rd_data = mem[rd_ptr];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage carries data only; no reset needed.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wr_data;
    end

endmodule

// File: rtl/mmio_uart_tx.sv
// ---------------------------------------------------------------------------
// mmio_uart_tx
// Memory-mapped 8N1 UART transmitter sitting on a data-memory bank.
// Stores push bytes into a TX FIFO; the FSM serialises them LSB first on txd.
// Loads are answered combinationally.
// Ports:
//   clk, reset_n   clock, asynchronous active-low reset
//   en             bank select
//   memWrite[3:0]  byte-lane write enables (bit 0 = lane [7:0])
//   addr[10:0]     word address, only addr[1:0] decoded
//   wdata[31:0]    lane-aligned store data
//   rdata[31:0]    load data, 0 when en=0
//   txd            registered serial output, idles high
//   irq            EN set, FIFO empty and transmitter idle
// ---------------------------------------------------------------------------
module mmio_uart_tx
    import uart_pkg::*;
#(
    parameter int          FIFO_DEPTH  = 8,
    parameter logic [15:0] DEFAULT_DIV = 16'd434
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        en,
    input  logic [3:0]  memWrite,
    input  logic [10:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        txd,
    output logic        irq
);

    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

    // Register file
    logic [15:0] div;
    logic        ctrl_en;
    logic        ovf;

    // FIFO interface
    logic             fifo_push;
    logic             fifo_pop;
    logic [7:0]       fifo_head;
    logic             fifo_full;
    logic             fifo_empty;
    logic [CNT_W-1:0] fifo_count;

    // Transmitter
    uart_tx_state_t state, next_state;
    logic [15:0]    bit_cnt, bit_cnt_next;
    logic [2:0]     bit_idx, bit_idx_next;
    logic [7:0]     shreg, shreg_next;
    logic           txd_next;
    logic [15:0]    div_eff;
    logic [15:0]    reload;
    logic           bit_end;

    logic [1:0] sel;
    logic       lane0_wr;
    logic       overflow;
    logic       ovf_clr;
    logic       unused_bits;

    assign sel       = addr[1:0];
    assign lane0_wr  = en && memWrite[0];
    assign fifo_push = lane0_wr && (sel == UART_TXDATA);
    // A dropped byte: FIFO full and no pop to make room this cycle.
    assign overflow  = fifo_push && fifo_full && !fifo_pop;
    assign ovf_clr   = lane0_wr && (sel == UART_STATUS) && wdata[STAT_OVF];
    assign unused_bits = ^{addr[10:2], wdata[31:16], memWrite[3:2]};

    sync_fifo #(
        .DATA_W (8),
        .DEPTH  (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .push    (fifo_push),
        .wr_data (wdata[7:0]),
        .pop     (fifo_pop),
        .rd_data (fifo_head),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (fifo_count)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            div     <= DEFAULT_DIV;
            ctrl_en <= 1'b0;
            ovf     <= 1'b0;
        end else begin
            if (en && sel == UART_DIV && memWrite[0]) div[7:0]  <= wdata[7:0];
            if (en && sel == UART_DIV && memWrite[1]) div[15:8] <= wdata[15:8];
            if (lane0_wr && sel == UART_CTRL)         ctrl_en   <= wdata[CTRL_EN];
            if (overflow)     ovf <= 1'b1;
            else if (ovf_clr) ovf <= 1'b0;
        end
    end

    // A divider of 0 behaves as 1 cycle per bit.
    assign div_eff = (div == 16'd0) ? 16'd1 : div;
    assign reload  = div_eff - 16'd1;
    assign bit_end = (bit_cnt == 16'd0);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state   <= TX_IDLE;
            bit_cnt <= '0;
            bit_idx <= '0;
            txd     <= 1'b1;
        end else begin
            state   <= next_state;
            bit_cnt <= bit_cnt_next;
            bit_idx <= bit_idx_next;
            txd     <= txd_next;
        end
    end

    always_ff @(posedge clk) begin
        shreg <= shreg_next;
    end

    // Divider is sampled only at bit boundaries, so a mid-bit DIV write
    // affects the following bit.
    always_comb begin
        next_state   = state;
        bit_cnt_next = bit_end ? bit_cnt : bit_cnt - 16'd1;
        bit_idx_next = bit_idx;
        shreg_next   = shreg;
        txd_next     = txd;
        fifo_pop     = 1'b0;
        case (state)
            TX_IDLE: begin
                if (ctrl_en && !fifo_empty) begin
                    next_state   = TX_START;
                    fifo_pop     = 1'b1;
                    shreg_next   = fifo_head;
                    bit_cnt_next = reload;
                    txd_next     = 1'b0;
                end
            end
            TX_START: begin
                if (bit_end) begin
                    next_state   = TX_DATA;
                    bit_cnt_next = reload;
                    bit_idx_next = 3'd0;
                    txd_next     = shreg[0];
                    shreg_next   = shreg >> 1;
                end
            end
            TX_DATA: begin
                if (bit_end) begin
                    bit_cnt_next = reload;
                    if (bit_idx == 3'd7) begin
                        next_state = TX_STOP;
                        txd_next   = 1'b1;
                    end else begin
                        bit_idx_next = bit_idx + 3'd1;
                        txd_next     = shreg[0];
                        shreg_next   = shreg >> 1;
                    end
                end
            end
            TX_STOP: begin
                if (bit_end) begin
                    bit_cnt_next = reload;
                    // Chain straight into the next start bit: no idle gap.
                    if (ctrl_en && !fifo_empty) begin
                        next_state = TX_START;
                        fifo_pop   = 1'b1;
                        shreg_next = fifo_head;
                        txd_next   = 1'b0;
                    end else begin
                        next_state = TX_IDLE;
                        txd_next   = 1'b1;
                    end
                end
            end
            default: begin
                next_state = TX_IDLE;
                txd_next   = 1'b1;
            end
        endcase
    end

    assign irq = ctrl_en && fifo_empty && (state == TX_IDLE);

    always_comb begin
        rdata = '0;
        if (en) begin
            case (sel)
                UART_STATUS: begin
                    rdata[STAT_FULL]  = fifo_full;
                    rdata[STAT_EMPTY] = fifo_empty;
                    rdata[STAT_BUSY]  = (state != TX_IDLE);
                    rdata[STAT_OVF]   = ovf;
                    rdata[STAT_COUNT_LSB +: STAT_COUNT_W] = STAT_COUNT_W'(fifo_count);
                end
                UART_DIV:  rdata[15:0]    = div;
                UART_CTRL: rdata[CTRL_EN] = ctrl_en;
                default:   rdata          = '0;
            endcase
        end
    end

endmodule

// File: tb/tb_mmio_uart_tx.sv
module tb_mmio_uart_tx;

    logic        clk;
    logic        reset_n;
    logic        en;
    logic [3:0]  memWrite;
    logic [10:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        txd;
    logic        irq;

    int errors = 0;
    int checks = 0;
    logic [31:0] v;

    mmio_uart_tx #(
        .FIFO_DEPTH  (8),
        .DEFAULT_DIV (16'd434)
    ) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .en       (en),
        .memWrite (memWrite),
        .addr     (addr),
        .wdata    (wdata),
        .rdata    (rdata),
        .txd      (txd),
        .irq      (irq)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic bus_write(input logic [1:0] a, input logic [31:0] d, input logic [3:0] be);
        @(negedge clk);
        en = 1'b1; addr = {9'd0, a}; wdata = d; memWrite = be;
        @(negedge clk);
        en = 1'b0; addr = '0; wdata = '0; memWrite = 4'd0;
    endtask

    task automatic bus_read(input logic [1:0] a, output logic [31:0] d);
        en = 1'b1; addr = {9'd0, a}; memWrite = 4'd0;
        #1;
        d = rdata;
        en = 1'b0; addr = '0;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (txd !== 1'b1) begin errors++; $display("FAIL reset_txd: got %b expected 1", txd); end
        checks++; if (irq !== 1'b0) begin errors++; $display("FAIL reset_irq: got %b expected 0", irq); end
        bus_read(2'd1, v);
        checks++; if (v !== 32'h0000_0002) begin errors++; $display("FAIL reset_status: got %h expected 00000002", v); end
        bus_read(2'd2, v);
        checks++; if (v !== 32'd434) begin errors++; $display("FAIL reset_div: got %0d expected 434", v); end
        bus_read(2'd3, v);
        checks++; if (v !== 32'd0) begin errors++; $display("FAIL reset_ctrl: got %h expected 0", v); end
        bus_read(2'd0, v);
        checks++; if (v !== 32'd0) begin errors++; $display("FAIL reset_txdata_read: got %h expected 0", v); end
        en = 1'b0; addr = 11'd1; #1;
        checks++; if (rdata !== 32'd0) begin errors++; $display("FAIL rdata_en_low: got %h expected 0", rdata); end
        addr = '0;
    endtask

    task automatic test_frame_a5();
        logic [9:0] frame;
        frame = {1'b1, 8'hA5, 1'b0};
        do_reset();
        bus_write(2'd2, 32'd4, 4'b0011);
        bus_write(2'd3, 32'd1, 4'b0001);
        checks++; if (irq !== 1'b1) begin errors++; $display("FAIL a5_irq_idle_en: got %b expected 1", irq); end
        bus_write(2'd0, 32'hA5, 4'b0001);
        checks++; if (txd !== 1'b1) begin errors++; $display("FAIL a5_txd_before_pop: got %b expected 1", txd); end
        bus_read(2'd1, v);
        checks++; if (v !== 32'h0000_0100) begin errors++; $display("FAIL a5_status_after_push: got %h expected 00000100", v); end
        for (int i = 0; i <= 40; i++) begin
            @(negedge clk);
            if (i < 40) begin
                checks++;
                if (txd !== frame[i/4]) begin errors++; $display("FAIL a5_txd cycle %0d: got %b expected %b", i, txd, frame[i/4]); end
            end
            if (i == 39) begin
                checks++; if (irq !== 1'b0) begin errors++; $display("FAIL a5_irq_in_stop: got %b expected 0", irq); end
            end
            if (i == 40) begin
                checks++; if (irq !== 1'b1) begin errors++; $display("FAIL a5_irq_after_frame: got %b expected 1", irq); end
                checks++; if (txd !== 1'b1) begin errors++; $display("FAIL a5_txd_idle: got %b expected 1", txd); end
            end
        end
    endtask

    task automatic test_overflow();
        do_reset();
        for (int j = 0; j < 9; j++) begin
            bus_write(2'd0, 32'(j), 4'b0001);
            if (j == 0) begin
                bus_read(2'd1, v);
                checks++; if (v !== 32'h0000_0100) begin errors++; $display("FAIL ovf_count1: got %h expected 00000100", v); end
            end
            if (j == 7) begin
                bus_read(2'd1, v);
                checks++; if (v !== 32'h0000_0801) begin errors++; $display("FAIL ovf_full_no_ovf: got %h expected 00000801", v); end
            end
        end
        bus_read(2'd1, v);
        checks++; if (v !== 32'h0000_0809) begin errors++; $display("FAIL ovf_set: got %h expected 00000809", v); end
        checks++; if (irq !== 1'b0) begin errors++; $display("FAIL ovf_irq_en0: got %b expected 0", irq); end
        bus_write(2'd1, 32'h0, 4'b0001);
        bus_read(2'd1, v);
        checks++; if (v !== 32'h0000_0809) begin errors++; $display("FAIL ovf_write0_keeps: got %h expected 00000809", v); end
        bus_write(2'd1, 32'h8, 4'b0001);
        bus_read(2'd1, v);
        checks++; if (v !== 32'h0000_0801) begin errors++; $display("FAIL ovf_w1c: got %h expected 00000801", v); end
    endtask

    task automatic test_back_to_back();
        logic [19:0] frames;
        frames = {1'b1, 8'h02, 1'b0, 1'b1, 8'h01, 1'b0};
        do_reset();
        bus_write(2'd2, 32'd4, 4'b0011);
        bus_write(2'd3, 32'd1, 4'b0001);
        @(negedge clk);
        en = 1'b1; addr = 11'd0; wdata = 32'h01; memWrite = 4'b0001;
        @(negedge clk);
        wdata = 32'h02;
        @(negedge clk);
        memWrite = 4'd0; wdata = '0; addr = 11'd1;
        for (int i = 0; i <= 80; i++) begin
            if (i > 0) @(negedge clk);
            #1;
            if (i < 80) begin
                checks++;
                if (txd !== frames[i/4]) begin errors++; $display("FAIL b2b_txd cycle %0d: got %b expected %b", i, txd, frames[i/4]); end
                checks++;
                if (rdata[2] !== 1'b1) begin errors++; $display("FAIL b2b_busy cycle %0d: got %b expected 1", i, rdata[2]); end
            end
            if (i == 0) begin
                checks++; if (rdata !== 32'h0000_0104) begin errors++; $display("FAIL b2b_status_first: got %h expected 00000104", rdata); end
            end
            if (i == 40) begin
                checks++; if (rdata !== 32'h0000_0006) begin errors++; $display("FAIL b2b_status_second: got %h expected 00000006", rdata); end
            end
            if (i == 80) begin
                checks++; if (rdata !== 32'h0000_0002) begin errors++; $display("FAIL b2b_status_end: got %h expected 00000002", rdata); end
                checks++; if (irq !== 1'b1) begin errors++; $display("FAIL b2b_irq_end: got %b expected 1", irq); end
            end
        end
        en = 1'b0; addr = '0;
    endtask

    task automatic test_div_change();
        logic [7:0] data;
        logic       e;
        data = 8'h55;
        do_reset();
        bus_write(2'd2, 32'd4, 4'b0011);
        bus_write(2'd3, 32'd1, 4'b0001);
        bus_write(2'd0, 32'h55, 4'b0001);
        for (int i = 0; i <= 27; i++) begin
            @(negedge clk);
            if (i < 4)       e = 1'b0;
            else if (i < 20) e = data[(i-4)/8];
            else if (i < 26) e = data[i-18];
            else             e = 1'b1;
            checks++;
            if (txd !== e) begin errors++; $display("FAIL div_txd cycle %0d: got %b expected %b", i, txd, e); end
            if (i == 26) begin
                checks++; if (irq !== 1'b0) begin errors++; $display("FAIL div_irq_stop: got %b expected 0", irq); end
            end
            if (i == 27) begin
                checks++; if (irq !== 1'b1) begin errors++; $display("FAIL div_irq_idle: got %b expected 1", irq); end
            end
            if (i == 1) begin
                en = 1'b1; addr = 11'd2; wdata = 32'd8; memWrite = 4'b0011;
            end else if (i == 13) begin
                en = 1'b1; addr = 11'd2; wdata = 32'd0; memWrite = 4'b0011;
            end else begin
                en = 1'b0; addr = '0; wdata = '0; memWrite = 4'd0;
            end
        end
        bus_read(2'd2, v);
        checks++; if (v !== 32'd0) begin errors++; $display("FAIL div_readback_zero: got %h expected 0", v); end
    endtask

    task automatic test_reset_midframe();
        do_reset();
        bus_write(2'd2, 32'd4, 4'b0011);
        bus_write(2'd3, 32'd1, 4'b0001);
        bus_write(2'd0, 32'h00, 4'b0001);
        bus_write(2'd0, 32'h00, 4'b0001);
        repeat (6) @(negedge clk);
        checks++; if (txd !== 1'b0) begin errors++; $display("FAIL rst_mid_txd_low: got %b expected 0", txd); end
        reset_n = 1'b0;
        #1;
        checks++; if (txd !== 1'b1) begin errors++; $display("FAIL rst_async_txd: got %b expected 1", txd); end
        checks++; if (irq !== 1'b0) begin errors++; $display("FAIL rst_async_irq: got %b expected 0", irq); end
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        bus_read(2'd1, v);
        checks++; if (v !== 32'h0000_0002) begin errors++; $display("FAIL rst_status_after: got %h expected 00000002", v); end
        bus_read(2'd3, v);
        checks++; if (v !== 32'd0) begin errors++; $display("FAIL rst_ctrl_after: got %h expected 0", v); end
        bus_write(2'd3, 32'd1, 4'b0001);
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            checks++;
            if (txd !== 1'b1) begin errors++; $display("FAIL rst_residual_txd cycle %0d: got %b expected 1", i, txd); end
        end
        bus_read(2'd1, v);
        checks++; if (v !== 32'h0000_0002) begin errors++; $display("FAIL rst_status_final: got %h expected 00000002", v); end
        checks++; if (irq !== 1'b1) begin errors++; $display("FAIL rst_irq_final: got %b expected 1", irq); end
    endtask

    initial begin
        reset_n  = 1'b0;
        en       = 1'b0;
        memWrite = 4'd0;
        addr     = '0;
        wdata    = '0;
        test_reset();
        test_frame_a5();
        test_overflow();
        test_back_to_back();
        test_div_change();
        test_reset_midframe();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
